// File: rtl/rv32e_program_loader_if.sv
// Host load port and CPU fetch port of the rv32e program loader.
// The master side is the host/CPU pair, the slave side is the loader itself.
interface rv32e_program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  load_start;
    logic [7:0]            load_byte;
    logic                  load_valid;
    logic                  load_ready;
    logic                  load_done;
    logic                  loading;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  load_error;
    logic [7:0]            load_checksum;
    logic                  cpu_reset;
    logic [31:0]           mem_program_addr_bus;
    logic [31:0]           mem_program_data_bus;

    modport master (
        output load_start, load_byte, load_valid, load_done, mem_program_addr_bus,
        input  load_ready, loading, load_count, load_error, load_checksum, cpu_reset,
               mem_program_data_bus
    );

    modport slave (
        input  load_start, load_byte, load_valid, load_done, mem_program_addr_bus,
        output load_ready, loading, load_count, load_error, load_checksum, cpu_reset,
               mem_program_data_bus
    );
endinterface

// File: rtl/rv32e_program_loader.sv
// rv32e program memory with a host byte-stream loader.
// Little-endian bytes are packed into 32-bit words; the CPU is held in reset
// (cpu_reset low) while a load session runs and for two cycles afterwards.
// Optional feature macro: PROGMEM_CHECKSUM_EN (8-bit wrapping byte sum).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no session; CPU released, memory served to fetch port
// LOAD    | accepting host bytes, packing words
// FLUSH   | one cycle: write any partial word (unfilled lanes zero)
// RELEASE | two cycles: CPU still in reset before returning to IDLE
module rv32e_program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    rv32e_program_loader_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // waddr value meaning "memory full"; writes here are dropped
    localparam logic [ADDR_WIDTH:0] WADDR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        FLUSH   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state, next_state;
    logic [1:0]          byte_idx;
    logic [23:0]         word_buf;
    logic [ADDR_WIDTH:0] waddr;
    logic                load_error_q;
    logic                cpu_reset_q;
    logic                rel_cnt;
    logic                accept;
    logic                wr_en;
    logic [31:0]         wr_data;
    logic                mem_we;
    logic [31:0]         mem [DEPTH];

    // A restart pulse takes priority over a byte offered in the same cycle.
    assign accept = (state == LOAD) && bus.load_valid && !bus.load_start;
    assign mem_we = wr_en && (waddr != WADDR_FULL);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and word-write decode
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_data    = '0;
        case (state)
            IDLE: begin
                next_state = IDLE;
            end
            LOAD: begin
                if (accept && byte_idx == 2'd3) begin
                    wr_en   = 1'b1;
                    wr_data = {bus.load_byte, word_buf};
                end
                if (bus.load_done) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (byte_idx != 2'd0) begin
                    wr_en   = 1'b1;
                    wr_data = {8'h00, word_buf};
                end
                next_state = RELEASE;
            end
            RELEASE: begin
                if (rel_cnt == 1'b0) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (bus.load_start) begin
            next_state = LOAD;
            wr_en      = 1'b0;
        end
    end

    // Byte packing, write address/count, overflow flag, release timer, CPU reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx     <= 2'd0;
            word_buf     <= '0;
            waddr        <= '0;
            load_error_q <= 1'b0;
            rel_cnt      <= 1'b0;
            cpu_reset_q  <= 1'b0;
        end else begin
            cpu_reset_q <= (next_state == IDLE);
            if (state == FLUSH) begin
                rel_cnt <= 1'b1;
            end else if (state == RELEASE && rel_cnt != 1'b0) begin
                rel_cnt <= rel_cnt - 1'b1;
            end
            if (bus.load_start) begin
                byte_idx     <= 2'd0;
                word_buf     <= '0;
                waddr        <= '0;
                load_error_q <= 1'b0;
            end else begin
                if (accept) begin
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    word_buf[7:0]   <= bus.load_byte;
                        2'd1:    word_buf[15:8]  <= bus.load_byte;
                        2'd2:    word_buf[23:16] <= bus.load_byte;
                        default: word_buf        <= '0;
                    endcase
                end
                if (state == FLUSH) begin
                    byte_idx <= 2'd0;
                    word_buf <= '0;
                end
                if (wr_en) begin
                    if (waddr == WADDR_FULL) begin
                        load_error_q <= 1'b1;
                    end else begin
                        waddr <= waddr + 1'b1;
                    end
                end
            end
        end
    end

    // Program memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Fetch read path: out-of-range or mid-load fetches see a NOP
    always_comb begin
        bus.mem_program_data_bus = NOP;
        if (bus.mem_program_addr_bus[31:ADDR_WIDTH] == '0 && !bus.loading) begin
            bus.mem_program_data_bus = mem[bus.mem_program_addr_bus[ADDR_WIDTH-1:0]];
        end
    end

`ifdef PROGMEM_CHECKSUM_EN
    logic [7:0] checksum_q;

    // Wrapping sum of accepted bytes for the current session
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= 8'h00;
        end else if (bus.load_start) begin
            checksum_q <= 8'h00;
        end else if (accept) begin
            checksum_q <= checksum_q + bus.load_byte;
        end
    end

    assign bus.load_checksum = checksum_q;
`else
    assign bus.load_checksum = 8'h00;
`endif

    assign bus.load_ready = (state == LOAD);
    assign bus.loading    = (state == LOAD) || (state == FLUSH);
    assign bus.load_count = waddr;
    assign bus.load_error = load_error_q;
    assign bus.cpu_reset  = cpu_reset_q;
endmodule

// File: tb/tb_rv32e_program_loader.sv
// Bench for rv32e_program_loader: one instance at ADDR_WIDTH=8, one at
// ADDR_WIDTH=2 for the overflow case. Stimulus queues expectations; a
// monitor drains and compares them on each falling clock edge.
module tb_rv32e_program_loader;
    localparam int SEL_DATA  = 0;
    localparam int SEL_COUNT = 1;
    localparam int SEL_ERR   = 2;
    localparam int SEL_CPURST = 3;
    localparam int SEL_READY = 4;
    localparam int SEL_LOADING = 5;
    localparam int SEL_CSUM  = 6;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       name;
        int          d;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        ld_start [2];
    logic        ld_valid [2];
    logic        ld_done [2];
    logic [7:0]  ld_byte [2];
    logic [31:0] rd_addr [2];
    chk_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rv32e_program_loader_if #(.ADDR_WIDTH(8)) bi0 ();
    rv32e_program_loader_if #(.ADDR_WIDTH(2)) bi1 ();

    assign bi0.load_start = ld_start[0];
    assign bi0.load_valid = ld_valid[0];
    assign bi0.load_done  = ld_done[0];
    assign bi0.load_byte  = ld_byte[0];
    assign bi0.mem_program_addr_bus = rd_addr[0];
    assign bi1.load_start = ld_start[1];
    assign bi1.load_valid = ld_valid[1];
    assign bi1.load_done  = ld_done[1];
    assign bi1.load_byte  = ld_byte[1];
    assign bi1.mem_program_addr_bus = rd_addr[1];

    rv32e_program_loader #(.ADDR_WIDTH(8)) dut0 (.clk(clk), .reset(rst_n[0]), .bus(bi0));
    rv32e_program_loader #(.ADDR_WIDTH(2)) dut1 (.clk(clk), .reset(rst_n[1]), .bus(bi1));

    function automatic logic [31:0] actual(int d, int sel);
        logic [31:0] v;
        v = '0;
        if (d == 0) begin
            case (sel)
                SEL_DATA:    v = bi0.mem_program_data_bus;
                SEL_COUNT:   v = 32'(bi0.load_count);
                SEL_ERR:     v = 32'(bi0.load_error);
                SEL_CPURST:  v = 32'(bi0.cpu_reset);
                SEL_READY:   v = 32'(bi0.load_ready);
                SEL_LOADING: v = 32'(bi0.loading);
                default:     v = 32'(bi0.load_checksum);
            endcase
        end else begin
            case (sel)
                SEL_DATA:    v = bi1.mem_program_data_bus;
                SEL_COUNT:   v = 32'(bi1.load_count);
                SEL_ERR:     v = 32'(bi1.load_error);
                SEL_CPURST:  v = 32'(bi1.cpu_reset);
                SEL_READY:   v = 32'(bi1.load_ready);
                SEL_LOADING: v = 32'(bi1.loading);
                default:     v = 32'(bi1.load_checksum);
            endcase
        end
        return v;
    endfunction

    // Monitor: compare every queued expectation against the DUT output
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            chk_t c;
            logic [31:0] a;
            c = exp_q.pop_front();
            a = actual(c.d, c.sel);
            n_checks++;
            if (a !== c.exp) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got %h, expected %h", c.name, c.d, a, c.exp);
            end
        end
    end

    task automatic chk(input int d, input int sel, input logic [31:0] e, input string name);
        chk_t c;
        c.name = name;
        c.d    = d;
        c.sel  = sel;
        c.exp  = e;
        exp_q.push_back(c);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_read(input int d, input logic [31:0] addr, input logic [31:0] e,
                            input string name);
        rd_addr[d] = addr;
        chk(d, SEL_DATA, e, name);
        sync();
    endtask

    task automatic start(input int d);
        ld_start[d] = 1'b1;
        tick();
        ld_start[d] = 1'b0;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        ld_byte[d]  = b;
        ld_valid[d] = 1'b1;
        tick();
        ld_valid[d] = 1'b0;
    endtask

    // load_done, then FLUSH and both RELEASE cycles back to IDLE
    task automatic finish(input int d);
        ld_done[d] = 1'b1;
        tick();
        ld_done[d] = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] prog1 [8];
        prog1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; ld_start[i] = 1'b0; ld_valid[i] = 1'b0;
            ld_done[i] = 1'b0; ld_byte[i] = 8'h00; rd_addr[i] = 32'h0;
        end

        // Reset values
        chk(0, SEL_CPURST, 0, "rst_cpu_reset");
        chk(0, SEL_READY, 0, "rst_ready");
        chk(0, SEL_COUNT, 0, "rst_count");
        chk(0, SEL_ERR, 0, "rst_error");
        chk(0, SEL_LOADING, 0, "rst_loading");
        chk(0, SEL_CSUM, 0, "rst_checksum");
        sync();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        chk(0, SEL_CPURST, 1, "cpu_reset_after_release");
        sync();

        // Two-word program, CPU reset window
        start(0);
        chk(0, SEL_CPURST, 0, "t1_cpu_reset_load");
        chk(0, SEL_LOADING, 1, "t1_loading");
        chk(0, SEL_READY, 1, "t1_ready");
        chk_read(0, 32'h5, NOP, "t4_read_while_loading");
        for (int i = 0; i < 8; i++) send_byte(0, prog1[i]);
        ld_done[0] = 1'b1;
        tick();
        ld_done[0] = 1'b0;
        chk(0, SEL_LOADING, 1, "t1_loading_flush");
        chk(0, SEL_CPURST, 0, "t1_cpu_reset_flush");
        chk(0, SEL_READY, 0, "t1_ready_flush");
        sync();
        tick();
        chk(0, SEL_CPURST, 0, "t1_cpu_reset_rel1");
        chk(0, SEL_LOADING, 0, "t1_loading_rel1");
        sync();
        tick();
        chk(0, SEL_CPURST, 0, "t1_cpu_reset_rel2");
        sync();
        tick();
        chk(0, SEL_CPURST, 1, "t1_cpu_reset_idle");
        chk(0, SEL_COUNT, 2, "t1_count");
        sync();
        chk_read(0, 32'h0, 32'h0000_0013, "t1_mem0");
        chk_read(0, 32'h1, 32'h0010_0093, "t1_mem1");
        chk_read(0, 32'h100, NOP, "t4_addr_0x100");
        chk_read(0, 32'h101, NOP, "t4_addr_0x101");

        // Partial last word is zero-filled
        start(0);
        send_byte(0, 8'h11); send_byte(0, 8'h22); send_byte(0, 8'h33);
        send_byte(0, 8'h44); send_byte(0, 8'hAB);
        finish(0);
        chk(0, SEL_COUNT, 2, "t2_count");
        chk(0, SEL_ERR, 0, "t2_error");
        sync();
        chk_read(0, 32'h0, 32'h4433_2211, "t2_mem0");
        chk_read(0, 32'h1, 32'h0000_00AB, "t2_mem1");

        // Byte and load_done in the same cycle: byte is kept
        start(0);
        ld_byte[0] = 8'h55;
        ld_valid[0] = 1'b1;
        ld_done[0] = 1'b1;
        tick();
        ld_valid[0] = 1'b0;
        ld_done[0] = 1'b0;
        repeat (3) tick();
        chk(0, SEL_COUNT, 1, "simul_done_count");
        sync();
        chk_read(0, 32'h0, 32'h0000_0055, "simul_done_mem0");

        // Checksum
        start(0);
        send_byte(0, 8'hFF);
        send_byte(0, 8'h02);
`ifdef PROGMEM_CHECKSUM_EN
        chk(0, SEL_CSUM, 8'h01, "t6_checksum");
`else
        chk(0, SEL_CSUM, 8'h00, "t6_checksum");
`endif
        sync();
        finish(0);
        chk(0, SEL_COUNT, 1, "t6_count");
        sync();
        chk_read(0, 32'h0, 32'h0000_02FF, "t6_mem0");

        // Reset in the middle of a load
        start(0);
        send_byte(0, 8'h01); send_byte(0, 8'h02); send_byte(0, 8'h03); send_byte(0, 8'h04);
        send_byte(0, 8'h05); send_byte(0, 8'h06);
        rst_n[0] = 1'b0;
        chk(0, SEL_READY, 0, "t5_ready_in_reset");
        chk(0, SEL_COUNT, 0, "t5_count_in_reset");
        chk(0, SEL_CPURST, 0, "t5_cpu_reset_in_reset");
        chk(0, SEL_LOADING, 0, "t5_loading_in_reset");
        sync();
        rst_n[0] = 1'b1;
        chk(0, SEL_CPURST, 1, "t5_cpu_reset_after");
        sync();
        chk_read(0, 32'h0, 32'h0403_0201, "t5_mem0_kept");
        chk_read(0, 32'h1, 32'h0000_00AB, "t5_mem1_untouched");

        // Overflow on a 4-word memory
        start(1);
        for (int i = 0; i < 20; i++) send_byte(1, 8'(i));
        chk(1, SEL_COUNT, 4, "t3_count_sat");
        chk(1, SEL_ERR, 1, "t3_error");
        sync();
        finish(1);
        chk(1, SEL_ERR, 1, "t3_error_sticky");
        sync();
        chk_read(1, 32'h0, 32'h0302_0100, "t3_mem0_unchanged");
        chk_read(1, 32'h3, 32'h0F0E_0D0C, "t3_mem3");
        chk_read(1, 32'h4, NOP, "t3_addr_out_of_range");
        start(1);
        chk(1, SEL_ERR, 0, "t3_error_cleared");
        chk(1, SEL_COUNT, 0, "t3_count_cleared");
        sync();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, expected end earlier", $time);
        $fatal(1, "watchdog");
    end
endmodule
